// File: rtl/instr_fetch.sv
// Fetch-side responder: owns the PC and runs a single outstanding read
// handshake to instruction memory, returning the latched op/operand to central.
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INST_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en_fetch,
    input  logic              r,
    input  logic              pc_en,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_din,
    input  logic [INST_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [2:0]        op,
    output logic [INST_W-4:0] operand,
    output logic              inst_valid,
    output logic              busy,
    output logic [ADDR_W-1:0] pc,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              rd_reg, rd_next;
    logic [2:0]        op_reg, op_next;
    logic [INST_W-4:0] operand_reg, operand_next;
    logic              valid_reg, valid_next;
    logic              busy_reg, busy_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    // Set when the PC is redirected while a read is outstanding, so the
    // completion does not step past the new target.
    logic              jumped_reg, jumped_next;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= IDLE;
            pc_reg      <= '0;
            addr_reg    <= '0;
            rd_reg      <= 1'b0;
            op_reg      <= '0;
            operand_reg <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
            jumped_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            addr_reg    <= addr_next;
            rd_reg      <= rd_next;
            op_reg      <= op_next;
            operand_reg <= operand_next;
            valid_reg   <= valid_next;
            busy_reg    <= busy_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
            jumped_reg  <= jumped_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        addr_next    = addr_reg;
        rd_next      = rd_reg;
        op_next      = op_reg;
        operand_next = operand_reg;
        valid_next   = 1'b0;
        busy_next    = busy_reg;
        err_next     = err_reg;
        cnt_next     = cnt_reg;
        jumped_next  = jumped_reg;

        case (state_reg)
            IDLE: begin
                if (en_fetch && r) begin
                    addr_next   = pc_reg;
                    rd_next     = 1'b1;
                    busy_next   = 1'b1;
                    err_next    = 1'b0;
                    cnt_next    = '0;
                    jumped_next = 1'b0;
                    state_next  = REQ;
                end
            end
            REQ: begin
                if (pc_load) begin
                    jumped_next = 1'b1;
                end
                if (mem_ack) begin
                    op_next      = mem_rdata[INST_W-1 -: 3];
                    operand_next = mem_rdata[INST_W-4:0];
                    valid_next   = 1'b1;
                    rd_next      = 1'b0;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                    if (pc_en && !jumped_reg) begin
                        pc_next = pc_reg + 1'b1;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    rd_next    = 1'b0;
                    busy_next  = 1'b0;
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // A jump overrides any increment in the same cycle.
        if (pc_load) begin
            pc_next = pc_din;
        end
    end

    assign mem_addr   = addr_reg;
    assign mem_rd     = rd_reg;
    assign op         = op_reg;
    assign operand    = operand_reg;
    assign inst_valid = valid_reg;
    assign busy       = busy_reg;
    assign pc         = pc_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected op/operand pairs are queued when the
// ack is driven and popped whenever inst_valid is seen.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       clr;
    logic       en_fetch, r, pc_en, pc_load, mem_ack;
    logic [7:0] pc_din, mem_rdata;
    logic [7:0] mem_addr, pc;
    logic       mem_rd, inst_valid, busy, err;
    logic [2:0] op;
    logic [4:0] operand;

    typedef struct packed {
        logic [2:0] op;
        logic [4:0] operand;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   iv_cnt = 0;
    int   hi;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .INST_W(8), .TIMEOUT(15)) dut (
        .clk        (clk),
        .clr        (clr),
        .en_fetch   (en_fetch),
        .r          (r),
        .pc_en      (pc_en),
        .pc_load    (pc_load),
        .pc_din     (pc_din),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .op         (op),
        .operand    (operand),
        .inst_valid (inst_valid),
        .busy       (busy),
        .pc         (pc),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample; any inst_valid pulse is scored here.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (inst_valid === 1'b1) begin
            iv_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_inst_valid", 32'(inst_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("sb_op", 32'(op), 32'(e.op));
                check("sb_operand", 32'(operand), 32'(e.operand));
                $display("txn: op=%0h operand=%0h pc=%0h", op, operand, pc);
            end
        end
    endtask

    task automatic push_exp(input logic [7:0] word);
        exp_t e;
        e.op      = word[7:5];
        e.operand = word[4:0];
        exp_q.push_back(e);
    endtask

    initial begin
        clr = 1'b0; en_fetch = 1'b0; r = 1'b0; pc_en = 1'b0; pc_load = 1'b0;
        mem_ack = 1'b0; pc_din = 8'h00; mem_rdata = 8'h00;
        tick(); tick();
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_mem_rd", 32'(mem_rd), 32'h0);
        check("rst_busy_err", 32'({busy, err, inst_valid}), 32'h0);
        clr = 1'b1;
        tick();

        // Reset mid-request must clear everything immediately.
        en_fetch = 1'b1; r = 1'b1;
        tick();
        en_fetch = 1'b0; r = 1'b0;
        check("t1_req_rd", 32'(mem_rd), 32'h1);
        #2 clr = 1'b0;
        #1;
        check("t1_async_rd", 32'(mem_rd), 32'h0);
        check("t1_async_busy", 32'(busy), 32'h0);
        check("t1_async_outs", 32'({mem_addr, pc, op, operand, err, inst_valid}), 32'h0);
        mem_ack = 1'b1; mem_rdata = 8'hFF;
        tick();
        clr = 1'b1;
        tick(); tick();
        mem_ack = 1'b0;
        check("t1_no_valid", 32'(iv_cnt), 32'h0);
        check("t1_idle_busy", 32'(busy), 32'h0);

        // Load PC to 0x05, then a zero-wait fetch.
        pc_load = 1'b1; pc_din = 8'h05;
        tick();
        pc_load = 1'b0;
        check("load_pc", 32'(pc), 32'h05);
        en_fetch = 1'b1; r = 1'b1; pc_en = 1'b1; mem_ack = 1'b1; mem_rdata = 8'hA7;
        tick();
        en_fetch = 1'b0; r = 1'b0;
        check("t2_addr", 32'(mem_addr), 32'h05);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_no_early_valid", 32'(inst_valid), 32'h0);
        push_exp(8'hA7);
        tick();
        mem_ack = 1'b0;
        check("t2_valid", 32'(inst_valid), 32'h1);
        check("t2_pc", 32'(pc), 32'h06);
        check("t2_done", 32'({busy, mem_rd}), 32'h0);
        tick();
        check("t2_one_pulse", 32'(inst_valid), 32'h0);
        check("t2_op_hold", 32'({op, operand}), 32'hA7);

        // Ack after three wait cycles.
        en_fetch = 1'b1; r = 1'b1;
        tick();
        en_fetch = 1'b0; r = 1'b0;
        hi = (mem_rd === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_rd === 1'b1) hi++;
            check("t3_addr_stable", 32'(mem_addr), 32'h06);
        end
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        push_exp(8'h3C);
        tick();
        mem_ack = 1'b0;
        check("t3_rd_cycles", 32'(hi), 32'd4);
        check("t3_valid_busy", 32'({inst_valid, busy, mem_rd}), 32'b100);
        check("t3_pc", 32'(pc), 32'h07);

        // Timeout with no ack.
        en_fetch = 1'b1; r = 1'b1;
        tick();
        en_fetch = 1'b0; r = 1'b0;
        hi = (mem_rd === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40 && mem_rd === 1'b1; i++) begin
            tick();
            if (mem_rd === 1'b1) hi++;
        end
        check("t4_rd_cycles", 32'(hi), 32'd15);
        check("t4_err", 32'(err), 32'h1);
        check("t4_busy", 32'(busy), 32'h0);
        check("t4_pc_kept", 32'(pc), 32'h07);
        check("t4_op_kept", 32'({op, operand}), 32'h3C);
        check("t4_valid_count", 32'(iv_cnt), 32'd2);
        en_fetch = 1'b1; r = 1'b1;
        tick();
        en_fetch = 1'b0; r = 1'b0;
        check("t4_err_cleared", 32'(err), 32'h0);
        mem_ack = 1'b1; mem_rdata = 8'hE2;
        push_exp(8'hE2);
        tick();
        mem_ack = 1'b0;
        check("t4_recover_pc", 32'(pc), 32'h08);

        // Ack while idle and en_fetch without r are both ignored.
        mem_ack = 1'b1; en_fetch = 1'b1; r = 1'b0;
        tick(); tick();
        mem_ack = 1'b0; en_fetch = 1'b0;
        check("idle_ignore", 32'({busy, mem_rd}), 32'h0);

        // PC wrap.
        pc_load = 1'b1; pc_din = 8'hFF;
        tick();
        pc_load = 1'b0;
        en_fetch = 1'b1; r = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h55;
        tick();
        en_fetch = 1'b0; r = 1'b0;
        check("t5_addr", 32'(mem_addr), 32'hFF);
        push_exp(8'h55);
        tick();
        mem_ack = 1'b0;
        check("t5_wrap", 32'(pc), 32'h00);

        // Load in the completion cycle wins; en_fetch in REQ is ignored.
        en_fetch = 1'b1; r = 1'b1;
        tick();
        tick();
        check("t6_req_hold", 32'({busy, mem_addr}), 32'h100);
        pc_load = 1'b1; pc_din = 8'h40; mem_ack = 1'b1; mem_rdata = 8'h9B;
        push_exp(8'h9B);
        tick();
        pc_load = 1'b0; mem_ack = 1'b0;
        check("t6_pc_load_wins", 32'(pc), 32'h40);
        check("t6_addr_kept", 32'(mem_addr), 32'h00);
        check("t6_no_accept_on_done", 32'(busy), 32'h0);
        tick();
        en_fetch = 1'b0; r = 1'b0;
        check("t6_next_accept", 32'({busy, mem_addr}), 32'h140);
        pc_en = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h01;
        push_exp(8'h01);
        tick();
        mem_ack = 1'b0;
        check("t6_no_inc", 32'(pc), 32'h40);
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        check("valid_total", 32'(iv_cnt), 32'd6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
